load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the RV32I core's execute stage and the word-only, negedge-clocked data memory.
//  Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  Sign/zero-extends load data and performs read-modify-write for sub-word stores.
//  Flags misaligned and out-of-range accesses without touching memory.
// PARAMETERS
//  MEM_WORDS  16  depth of the attached memory in 32-bit words; byte addr must be < 4*MEM_WORDS
// PORTS
//  clk              in   1   core clock; all state updates on posedge
//  rst_n            in   1   asynchronous, active-low reset
//  req_valid        in   1   request present
//  req_ready        out  1   LSU idle; a request is accepted when req_valid & req_ready
//  req_write        in   1   1=store, 0=load
//  req_funct3       in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data; low byte/half used for SB/SH
//  resp_valid       out  1   one-cycle pulse: request complete
//  resp_rdata       out  32  extended load data; 0 for stores and errors
//  resp_error       out  1   valid with resp_valid: misaligned, bad funct3, or out of range
//  mem_address      out  32  word index = req_addr >> 2, upper bits zero
//  mem_data_in      out  32  write word to memory
//  mem_write_enable out  1   memory write strobe
//  mem_data_out     in   32  memory read word; updated by memory on negedge
// BEHAVIOUR
//  Interface: clk and rst_n, asynchronous active-low reset; single clock domain.
//  All outputs are registered.
//  Reset values: req_ready=1; resp_valid=0, resp_error=0, mem_write_enable=0; all data/address outputs 0.
//  FSM states: IDLE, READ, WRITE, RESP.
//   IDLE: on accept, latch funct3/addr/wdata/write and check for errors.
//    - Error: -> RESP with resp_error=1; no memory access.
//    - SW: drive mem_data_in=wdata, we=1 -> WRITE.
//    - Otherwise: drive mem_address, we=0 -> READ.
//   READ: memory returns the word at the intervening negedge; capture mem_data_out.
//    - Load: extract lane addr[1:0] and extend -> RESP.
//    - SB/SH: merge the byte/half into the captured word, we=1 -> WRITE.
//   WRITE: memory writes at the intervening negedge; clear we -> RESP.
//   RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready=1 again in the following cycle.
//  Latency from accept edge to resp_valid high:
//   - error: 1 cycle
//   - load: 2 cycles
//   - SW: 2 cycles
//   - SB/SH: 3 cycles
//  mem_write_enable is high for exactly one clock per store and never for loads or errors.
//  Alignment rules:
//   - H/HU/SH need addr[0]=0.
//   - W/SW need addr[1:0]=0.
//   - Byte accesses are always aligned.
//  Bad funct3: 011/110/111, and stores with funct3[2]=1 -> error.
//  Out of range: addr >= 4*MEM_WORDS -> error.
//  Lane mapping is little-endian: byte k = word[8k+7:8k]; half at addr[1]=1 is word[31:16].
//  req_valid outside IDLE is ignored; the request stays pending upstream.
//  Reset mid-operation: asynchronous return to IDLE; we drops immediately; no response is issued.
//   A WRITE is committed only if rst_n is high at that WRITE cycle's negedge.
//  Memory outputs hold their last value between accesses; only we matters for correctness.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B/H/W/BU/HU) and the state encoding (IDLE/READ/WRITE/RESP).
//  Sub-module lsu_align (combinational): load extraction/extension and store lane merge.
//   Inputs: funct3, addr[1:0], word, wdata. Outputs: load value, merged word, misaligned flag.
// TESTING
//  1. Memory word 3 = 32'h8070_F0A5.
//     LB addr 12 -> 32'hFFFF_FFA5; LBU addr 13 -> 32'h0000_00F0; LH addr 14 -> 32'hFFFF_8070.
//     Each response comes 2 cycles after accept, with resp_error=0.
//  2. Memory word 3 = 32'h8070_F0A5; SB addr 13, wdata 32'h0000_0011.
//     -> we high for one clock; word 3 becomes 32'h8070_11A5; resp_valid 3 cycles after accept.
//  3. SW addr 8, wdata 32'hDEAD_BEEF -> no read cycle; word 2 = 32'hDEADBEEF; then LW addr 8 returns it.
//  4. Error cases, each -> resp_error=1 after 1 cycle, we never asserted, memory unchanged:
//     LH addr 5; SW addr 6; LW addr 64 (MEM_WORDS=16); load funct3 3'b011.
//  5. Assert rst_n low during READ of an SH to addr 4.
//     -> immediate IDLE, no resp_valid, word 1 unchanged, req_ready=1.
//  6. Back-to-back: hold req_valid for LW then SW.
//     -> second request is accepted only on the cycle after RESP; req_ready=0 throughout the first.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes,
// the controller state encoding, and a funct3 legality helper.
// No ports; imported by lsu_align and load_store_unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Stores only have signed-size encodings; loads accept the five RV32I codes.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic write);
    logic bad;
    if (write) begin
      bad = f3[2] || (f3[1:0] == 2'b11);
    end else begin
      bad = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU));
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose: byte-lane extraction/extension for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; ports are funct3, addr_lo, word, wdata -> load_value, merged_word, misaligned.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_value,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Little-endian lanes: byte k lives at word[8k+7:8k].
  assign lane_byte = word[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_value = '0;
    case (funct3)
      F3_B:    load_value = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_value = {24'h0, lane_byte};
      F3_H:    load_value = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_value = {16'h0, lane_half};
      F3_W:    load_value = word;
      default: load_value = '0;
    endcase
  end

  always_comb begin
    merged_word = wdata;
    if (funct3[1:0] == 2'b00) begin
      merged_word = word;
      merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3[1:0] == 2'b01) begin
      merged_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = |addr_lo;
      default:     misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: turns RV32I byte-addressed loads/stores into word accesses on a negedge memory.
// Latency: accept->resp_valid is 1 (error), 2 (load, SW) or 3 (SB/SH read-modify-write) cycles.
// Backpressure: req_ready is low from accept until the cycle after the response pulse.
// Ports: req_* request channel in, resp_* one-cycle response out, mem_* word memory interface.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_t      state, state_next;
  logic [2:0]  cur_funct3, cur_funct3_next;
  logic [1:0]  cur_addr_lo, cur_addr_lo_next;
  logic [31:0] cur_wdata, cur_wdata_next;
  logic        cur_write, cur_write_next;

  logic        req_ready_next, resp_valid_next, resp_error_next, mem_we_next;
  logic [31:0] resp_rdata_next, mem_address_next, mem_data_in_next;

  logic        accept, req_bad;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_load_value, al_merged_word;
  logic        al_misaligned;

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign al_funct3  = (state == IDLE) ? req_funct3    : cur_funct3;
  assign al_addr_lo = (state == IDLE) ? req_addr[1:0] : cur_addr_lo;

  lsu_align u_align (
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .word        (mem_data_out),
    .wdata       (cur_wdata),
    .load_value  (al_load_value),
    .merged_word (al_merged_word),
    .misaligned  (al_misaligned)
  );

  assign accept  = req_valid && req_ready;
  assign req_bad = f3_illegal(req_funct3, req_write) || al_misaligned || (req_addr >= ADDR_LIMIT);

  always_comb begin
    state_next       = state;
    cur_funct3_next  = cur_funct3;
    cur_addr_lo_next = cur_addr_lo;
    cur_wdata_next   = cur_wdata;
    cur_write_next   = cur_write;
    resp_rdata_next  = '0;
    resp_error_next  = 1'b0;
    mem_address_next = mem_address;
    mem_data_in_next = mem_data_in;
    mem_we_next      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          cur_funct3_next  = req_funct3;
          cur_addr_lo_next = req_addr[1:0];
          cur_wdata_next   = req_wdata;
          cur_write_next   = req_write;
          if (req_bad) begin
            resp_error_next = 1'b1;
            state_next      = RESP;
          end else if (req_write && (req_funct3 == F3_W)) begin
            // Full-word store needs no read of the old word.
            mem_address_next = {2'b00, req_addr[31:2]};
            mem_data_in_next = req_wdata;
            mem_we_next      = 1'b1;
            state_next       = WRITE;
          end else begin
            mem_address_next = {2'b00, req_addr[31:2]};
            state_next       = READ;
          end
        end
      end
      READ: begin
        // mem_data_out was refreshed at the negedge inside this cycle.
        if (cur_write) begin
          mem_data_in_next = al_merged_word;
          mem_we_next      = 1'b1;
          state_next       = WRITE;
        end else begin
          resp_rdata_next = al_load_value;
          state_next      = RESP;
        end
      end
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    resp_valid_next = (state_next == RESP);
    req_ready_next  = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cur_funct3       <= '0;
      cur_addr_lo      <= '0;
      cur_wdata        <= '0;
      cur_write        <= 1'b0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      resp_rdata       <= '0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      state            <= state_next;
      cur_funct3       <= cur_funct3_next;
      cur_addr_lo      <= cur_addr_lo_next;
      cur_wdata        <= cur_wdata_next;
      cur_write        <= cur_write_next;
      req_ready        <= req_ready_next;
      resp_valid       <= resp_valid_next;
      resp_error       <= resp_error_next;
      resp_rdata       <= resp_rdata_next;
      mem_address      <= mem_address_next;
      mem_data_in      <= mem_data_in_next;
      mem_write_enable <= mem_we_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: negedge word memory model, directed vector table,
// reset/back-to-back sequences, and random traffic against a byte-level reference.
module tb_load_store_unit;

  localparam int MEM_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_write_enable;
  logic [31:0] resp_rdata, mem_address, mem_data_in;
  logic [31:0] mem_data_out = '0;

  logic [31:0] mem     [MEM_WORDS] = '{default: 32'h0};
  logic [31:0] ref_mem [MEM_WORDS] = '{default: 32'h0};

  int we_cnt = 0, resp_cnt = 0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  // Word memory: reads and writes on the falling edge.
  always @(negedge clk) begin
    if (mem_address < MEM_WORDS) begin
      if (mem_write_enable) mem[mem_address[3:0]] <= mem_data_in;
      mem_data_out <= mem[mem_address[3:0]];
    end
  end

  always @(posedge clk) if (mem_write_enable) we_cnt <= we_cnt + 1;
  always @(negedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory semantics computed with shifts and masks.
  task automatic ref_model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic err, output int lat, output int wes);
    int size, sh;
    logic [31:0] w, v, mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]) ||
          (addr >= 32'(4 * MEM_WORDS)) || ((addr % 32'(size)) != 0);
    rd = '0; wes = 0;
    if (err) begin
      lat = 1;
    end else begin
      w  = ref_mem[addr[5:2]];
      sh = int'(addr % 4) * 8;
      if (!wr) begin
        lat = 2;
        v = w >> sh;
        if (size == 1)      rd = (!f3[2] && v[7])  ? ((v & 32'hFF)   | 32'hFFFF_FF00) : (v & 32'hFF);
        else if (size == 2) rd = (!f3[2] && v[15]) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
        else                rd = w;
      end else begin
        wes = 1;
        if (size == 4) begin
          lat = 2;
          ref_mem[addr[5:2]] = wdata;
        end else begin
          lat  = 3;
          mask = ((32'h1 << (8 * size)) - 32'h1) << sh;
          ref_mem[addr[5:2]] = (w & ~mask) | ((wdata << sh) & mask);
        end
      end
    end
  endtask

  // Called and returns at posedge+1; issues one request and waits for its response.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic err, output int lat, output int wes);
    int w0;
    check("ready before request", 32'(req_ready), 32'h1);
    req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0 = we_cnt; lat = 0; rd = '0; err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin
        lat = k; rd = resp_rdata; err = resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    wes = we_cnt - w0;
    if (lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL response timeout: no resp_valid within 8 cycles");
    end else begin
      @(posedge clk); #1;
      check("resp_valid one cycle", 32'(resp_valid), 32'h0);
      check("ready after resp", 32'(req_ready), 32'h1);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rd;
    logic        exp_err;
    int          exp_lat, exp_we;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                  logic [31:0] exp_rd, logic exp_err, int exp_lat, int exp_we);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_we = exp_we;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd, m_rd;
    logic        err, m_err;
    int          lat, wes, m_lat, m_wes, rc0, nrand;
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    //            wr    f3      addr  wdata          exp_rdata      err  lat we
    add_vec(1'b1, 3'b010, 32'd12, 32'h8070_F0A5, 32'h0,         1'b0, 2, 1);
    add_vec(1'b1, 3'b010, 32'd4,  32'h1234_5678, 32'h0,         1'b0, 2, 1);
    add_vec(1'b0, 3'b000, 32'd12, 32'h0,         32'hFFFF_FFA5, 1'b0, 2, 0);
    add_vec(1'b0, 3'b100, 32'd13, 32'h0,         32'h0000_00F0, 1'b0, 2, 0);
    add_vec(1'b0, 3'b001, 32'd14, 32'h0,         32'hFFFF_8070, 1'b0, 2, 0);
    add_vec(1'b0, 3'b101, 32'd14, 32'h0,         32'h0000_8070, 1'b0, 2, 0);
    add_vec(1'b1, 3'b000, 32'd13, 32'h0000_0011, 32'h0,         1'b0, 3, 1);
    add_vec(1'b0, 3'b010, 32'd12, 32'h0,         32'h8070_11A5, 1'b0, 2, 0);
    add_vec(1'b1, 3'b010, 32'd8,  32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1);
    add_vec(1'b0, 3'b010, 32'd8,  32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0);
    add_vec(1'b0, 3'b001, 32'd5,  32'h0,         32'h0,         1'b1, 1, 0);
    add_vec(1'b1, 3'b010, 32'd6,  32'hFFFF_FFFF, 32'h0,         1'b1, 1, 0);
    add_vec(1'b0, 3'b010, 32'd64, 32'h0,         32'h0,         1'b1, 1, 0);
    add_vec(1'b0, 3'b011, 32'd0,  32'h0,         32'h0,         1'b1, 1, 0);
    add_vec(1'b1, 3'b100, 32'd0,  32'h0000_00FF, 32'h0,         1'b1, 1, 0);
    add_vec(1'b1, 3'b001, 32'd62, 32'h1234_ABCD, 32'h0,         1'b0, 3, 1);
    add_vec(1'b0, 3'b010, 32'd60, 32'h0,         32'hABCD_0000, 1'b0, 2, 0);
    add_vec(1'b0, 3'b001, 32'd62, 32'h0,         32'hFFFF_ABCD, 1'b0, 2, 0);
    add_vec(1'b0, 3'b100, 32'd63, 32'h0,         32'h0000_00AB, 1'b0, 2, 0);
    add_vec(1'b0, 3'b000, 32'd62, 32'h0,         32'hFFFF_FFCD, 1'b0, 2, 0);

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    check("reset req_ready", 32'(req_ready), 32'h1);
    check("reset resp_valid", 32'(resp_valid), 32'h0);
    check("reset resp_error", 32'(resp_error), 32'h0);
    check("reset we", 32'(mem_write_enable), 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset mem_address", mem_address, 32'h0);
    check("reset mem_data_in", mem_data_in, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      ref_model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat, m_wes);
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, wes);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d error", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d we pulses", i), 32'(wes), 32'(vecs[i].exp_we));
    end
    check("word3 after SB", mem[3], 32'h8070_11A5);
    check("word2 after SW", mem[2], 32'hDEAD_BEEF);
    check("word1 untouched by bad SW", mem[1], 32'h1234_5678);
    check("word0 untouched by bad SB", mem[0], 32'h0);

    // Reset during READ of an SH
    rc0 = resp_cnt;
    req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'd4; req_wdata = 32'h0000_5555; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    check("SH busy in READ", 32'(req_ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid-READ ready", 32'(req_ready), 32'h1);
    check("rst mid-READ we", 32'(mem_write_enable), 32'h0);
    check("rst mid-READ resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no resp after rst", 32'(resp_cnt - rc0), 32'h0);
    check("word1 after rst in READ", mem[1], 32'h1234_5678);

    // Reset during WRITE of an SW, before the committing negedge
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'd4; req_wdata = 32'hFFFF_0000; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    check("SW we in WRITE", 32'(mem_write_enable), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid-WRITE we drop", 32'(mem_write_enable), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("word1 after rst in WRITE", mem[1], 32'h1234_5678);
    check("no resp after rst WRITE", 32'(resp_cnt - rc0), 32'h0);

    // Back-to-back: LW then SW with req_valid held
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'd8; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'd16; req_wdata = 32'hCAFE_F00D;
    check("b2b ready in READ", 32'(req_ready), 32'h0);
    check("b2b no early resp", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    check("b2b ready in RESP", 32'(req_ready), 32'h0);
    check("b2b LW resp", 32'(resp_valid), 32'h1);
    check("b2b LW data", resp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("b2b ready after RESP", 32'(req_ready), 32'h1);
    check("b2b SW not yet accepted", 32'(mem_write_enable), 32'h0);
    @(posedge clk); #1 req_valid = 1'b0;
    check("b2b SW we", 32'(mem_write_enable), 32'h1);
    check("b2b ready in WRITE", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("b2b SW resp", 32'(resp_valid), 32'h1);
    check("b2b SW error", 32'(resp_error), 32'h0);
    @(posedge clk); #1;
    ref_model(1'b1, 3'b010, 32'd16, 32'hCAFE_F00D, m_rd, m_err, m_lat, m_wes);

    // Random traffic against the reference
    nrand = 150;
    for (int n = 0; n < nrand; n++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 71));
      r_wdata = 32'($urandom);
      ref_model(r_wr, r_f3, r_addr, r_wdata, m_rd, m_err, m_lat, m_wes);
      do_req(r_wr, r_f3, r_addr, r_wdata, rd, err, lat, wes);
      check($sformatf("rand%0d rdata", n), rd, m_rd);
      check($sformatf("rand%0d error", n), 32'(err), 32'(m_err));
      check($sformatf("rand%0d latency", n), 32'(lat), 32'(m_lat));
      check($sformatf("rand%0d we pulses", n), 32'(wes), 32'(m_wes));
    end
    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("final word%0d", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
